// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the BNN XNOR-popcount datapath.
package bnn_pkg;

    localparam int unsigned DATA_W  = 1280;
    localparam int unsigned CHUNK_W = 64;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned RD_LAT  = 2;

    typedef enum logic [2:0] {
        XP_IDLE  = 3'd0,
        XP_ISSUE = 3'd1,
        XP_WAIT  = 3'd2,
        XP_CAPT  = 3'd3,
        XP_ACC   = 3'd4,
        XP_OUT   = 3'd5,
        XP_DONE  = 3'd6
    } xp_state_t;

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational popcount of W bits as a balanced binary adder tree.
module popcnt_chunk #(
    parameter  int unsigned W     = 64,
    localparam int unsigned OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] count_o
);

    localparam int unsigned LVL = $clog2(W);
    localparam int unsigned P   = 1 << LVL;

    // Heap-ordered tree: node[1] is the root, leaves live at node[P +: P].
    logic [OUT_W-1:0] node [1:2*P-1];

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < W) begin : g_bit
            assign node[P+i] = OUT_W'(bits_i[i]);
        end else begin : g_pad
            assign node[P+i] = '0;
        end
    end

    for (genvar j = 1; j < P; j++) begin : g_sum
        assign node[j] = node[2*j] + node[2*j+1];
    end

    assign count_o = node[1];

endmodule

// File: rtl/bram_xnor_popcnt.sv
// Reads row pairs from a dual-port BRAM and returns popcount(XNOR(a, b)) per row
// over a valid/ready handshake, reducing CHUNK_W bits per cycle.
module bram_xnor_popcnt
    import bnn_pkg::*;
#(
    parameter  int unsigned DATA_W  = bnn_pkg::DATA_W,
    parameter  int unsigned CHUNK_W = bnn_pkg::CHUNK_W,
    parameter  int unsigned ADDR_W  = bnn_pkg::ADDR_W,
    parameter  int unsigned RD_LAT  = bnn_pkg::RD_LAT,
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk_a,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr_a,
    input  logic [ADDR_W-1:0] base_addr_b,
    input  logic [ADDR_W:0]   n_rows,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              ena_a,
    output logic              ena_b,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [ADDR_W-1:0] res_row
);

    localparam int unsigned N_CHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CH_W    = $clog2(N_CHUNK + 1);
    localparam int unsigned WAIT_W  = $clog2(RD_LAT + 1);
    localparam int unsigned PC_W    = $clog2(CHUNK_W + 1);
    localparam int unsigned ROW_W   = ADDR_W + 1;

    xp_state_t         state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  n_rows_q, n_rows_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CH_W-1:0]   chunk_q, chunk_d;
    logic [DATA_W-1:0] sa_q, sa_d;
    logic [DATA_W-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              ena_q, ena_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              res_valid_q, res_valid_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic [ADDR_W-1:0] res_row_q, res_row_d;

    logic [CHUNK_W-1:0] xnor_lo;
    logic [PC_W-1:0]    pc;
    logic [CNT_W-1:0]   acc_sum;
    logic [ROW_W-1:0]   row_inc;

    assign xnor_lo = ~(sa_q[CHUNK_W-1:0] ^ sb_q[CHUNK_W-1:0]);
    assign acc_sum = acc_q + CNT_W'(pc);
    assign row_inc = row_q + ROW_W'(1);

    popcnt_chunk #(
        .W (CHUNK_W)
    ) u_popcnt (
        .bits_i  (xnor_lo),
        .count_o (pc)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        n_rows_d    = n_rows_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        wait_d      = wait_q;
        chunk_d     = chunk_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        acc_d       = acc_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        ena_d       = 1'b0;
        done_d      = 1'b0;
        res_valid_d = 1'b0;
        res_count_d = res_count_q;
        res_row_d   = res_row_q;

        unique case (state_q)
            XP_IDLE: begin
                if (start) begin
                    row_d    = '0;
                    n_rows_d = n_rows;
                    base_a_d = base_addr_a;
                    base_b_d = base_addr_b;
                    if (n_rows == '0) begin
                        state_d = XP_DONE;
                    end else begin
                        state_d  = XP_ISSUE;
                        ena_d    = 1'b1;
                        addr_a_d = base_addr_a;
                        addr_b_d = base_addr_b;
                    end
                end
            end
            XP_ISSUE: begin
                wait_d = WAIT_W'(1);
                if (RD_LAT == 1) begin
                    state_d = XP_CAPT;
                end else begin
                    state_d = XP_WAIT;
                end
            end
            XP_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    state_d = XP_CAPT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            XP_CAPT: begin
                sa_d    = dout_a;
                sb_d    = dout_b;
                acc_d   = '0;
                chunk_d = '0;
                state_d = XP_ACC;
            end
            XP_ACC: begin
                acc_d   = acc_sum;
                sa_d    = sa_q >> CHUNK_W;
                sb_d    = sb_q >> CHUNK_W;
                chunk_d = chunk_q + CH_W'(1);
                if (chunk_q == CH_W'(N_CHUNK - 1)) begin
                    state_d     = XP_OUT;
                    res_valid_d = 1'b1;
                    res_count_d = acc_sum;
                    res_row_d   = row_q[ADDR_W-1:0];
                end
            end
            XP_OUT: begin
                res_valid_d = 1'b1;
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    row_d       = row_inc;
                    if (row_inc == n_rows_q) begin
                        state_d = XP_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = XP_ISSUE;
                        ena_d    = 1'b1;
                        addr_a_d = base_a_q + row_inc[ADDR_W-1:0];
                        addr_b_d = base_b_q + row_inc[ADDR_W-1:0];
                    end
                end
            end
            XP_DONE: begin
                // Zero-row jobs enter with done low and spend one extra cycle here.
                if (done_q) begin
                    state_d = XP_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = XP_IDLE;
        endcase

        busy_d = (state_d != XP_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= XP_IDLE;
            row_q       <= '0;
            n_rows_q    <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            wait_q      <= '0;
            chunk_q     <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            acc_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            ena_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            n_rows_q    <= n_rows_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            wait_q      <= wait_d;
            chunk_q     <= chunk_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            acc_q       <= acc_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            ena_q       <= ena_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            res_row_q   <= res_row_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign ena_a     = ena_q;
    assign ena_b     = ena_q;
    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_row   = res_row_q;

endmodule

// File: tb/tb_bram_xnor_popcnt.sv
// Directed bench for bram_xnor_popcnt with a 2-cycle BRAM model and result/address scoreboards.
module tb_bram_xnor_popcnt;

    localparam int DW = 1280;
    localparam int AW = 12;
    localparam int CW = 11;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } addr_exp_t;

    typedef struct {
        logic [CW-1:0] cnt;
        logic [AW-1:0] row;
    } res_exp_t;

    logic          clk_a = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr_a, base_addr_b;
    logic [AW:0]   n_rows;
    logic          busy, done;
    logic [AW-1:0] addr_a, addr_b;
    logic          ena_a, ena_b;
    logic [DW-1:0] dout_a = '0, dout_b = '0;
    logic [DW-1:0] pipe_a = '0, pipe_b = '0;
    logic          res_valid, res_ready;
    logic [CW-1:0] res_count;
    logic [AW-1:0] res_row;

    logic [DW-1:0] mem_a [logic [AW-1:0]];
    logic [DW-1:0] mem_b [logic [AW-1:0]];

    addr_exp_t addr_q[$];
    res_exp_t  exp_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_ena = 1'b0;

    always #5 clk_a = ~clk_a;

    bram_xnor_popcnt dut (
        .clk_a       (clk_a),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr_a (base_addr_a),
        .base_addr_b (base_addr_b),
        .n_rows      (n_rows),
        .busy        (busy),
        .done        (done),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .ena_a       (ena_a),
        .ena_b       (ena_b),
        .dout_a      (dout_a),
        .dout_b      (dout_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_row     (res_row)
    );

    function automatic logic [DW-1:0] rd_a(input logic [AW-1:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return '0;
    endfunction

    function automatic logic [DW-1:0] rd_b(input logic [AW-1:0] a);
        if (mem_b.exists(a)) return mem_b[a];
        return '0;
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [CW-1:0] model_cnt(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return CW'($countones(~(rd_a(a) ^ rd_b(b))));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // BRAM model: data for an enabled read appears RD_LAT=2 cycles later.
    always @(posedge clk_a) begin
        if (ena_a) pipe_a <= rd_a(addr_a);
        if (ena_b) pipe_b <= rd_b(addr_b);
        dout_a <= pipe_a;
        dout_b <= pipe_b;
    end

    // Address and result scoreboards.
    always @(negedge clk_a) begin
        if (!rst_n) begin
            prev_ena <= 1'b0;
        end else begin
            check("ena_match", 32'(ena_a), 32'(ena_b));
            if (ena_a) begin
                check("ena_single_cycle", 32'(prev_ena), 32'd0);
                check("issue_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) begin
                    addr_exp_t e;
                    e = addr_q.pop_front();
                    check("addr_a", 32'(addr_a), 32'(e.a));
                    check("addr_b", 32'(addr_b), 32'(e.b));
                end
            end
            if (res_valid && res_ready) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    res_exp_t r;
                    r = exp_q.pop_front();
                    check("res_count", 32'(res_count), 32'(r.cnt));
                    check("res_row", 32'(res_row), 32'(r.row));
                end
            end
            prev_ena <= ena_a;
        end
    end

    task automatic push_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW:0] n);
        for (int r = 0; r < int'(n); r++) begin
            addr_exp_t ae;
            res_exp_t  re;
            ae.a = ba + AW'(r);
            ae.b = bb + AW'(r);
            addr_q.push_back(ae);
            re.cnt = model_cnt(ae.a, ae.b);
            re.row = AW'(r);
            exp_q.push_back(re);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW:0] n);
        push_job(ba, bb, n);
        @(posedge clk_a); #1;
        start       = 1'b1;
        base_addr_a = ba;
        base_addr_b = bb;
        n_rows      = n;
        @(posedge clk_a); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int k);
        k = 0;
        do begin
            @(negedge clk_a);
            k++;
        end while (!done && k < max);
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr_a"}, 32'(addr_a), 32'd0);
        check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
        check({tag, "_ena"}, 32'({ena_a, ena_b}), 32'd0);
        check({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_count"}, 32'(res_count), 32'd0);
        check({tag, "_res_row"}, 32'(res_row), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k, k2;
        logic          got;
        logic [DW-1:0] r;
        logic [CW-1:0] hold_exp;

        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr_a = '0;
        base_addr_b = '0;
        n_rows      = '0;
        res_ready   = 1'b1;

        repeat (3) @(negedge clk_a);
        check_all_zero("reset");
        @(posedge clk_a); #1;
        rst_n = 1'b1;

        // Identical rows: full match, latency and done timing.
        r = rnd_row();
        mem_a[AW'(5)] = r;
        mem_b[AW'(5)] = r;
        start_job(AW'(5), AW'(5), 13'd1);
        got = 1'b0;
        k   = 0;
        while (!got && k < 60) begin
            @(negedge clk_a);
            k++;
            if (k == 1) check("t1_busy_after_start", 32'(busy), 32'd1);
            if (res_valid) got = 1'b1;
        end
        check("t1_valid_latency", 32'(k), 32'd24);
        check("t1_count_1280", 32'(res_count), 32'd1280);
        check("t1_row_0", 32'(res_row), 32'd0);
        wait_done("t1_done", 10, k2);
        check("t1_done_latency", 32'(k + k2), 32'd25);
        check("t1_busy_in_done", 32'(busy), 32'd1);
        @(negedge clk_a);
        check("t1_idle_after", 32'({busy, done}), 32'd0);

        // All-ones vs zeros gives 0; 0xAA.. vs zeros gives 640.
        r = '1;
        mem_a[AW'(20)] = r;
        for (int i = 0; i < DW; i++) r[i] = i[0];
        mem_a[AW'(21)] = r;
        mem_b[AW'(30)] = '0;
        mem_b[AW'(31)] = '0;
        check("t2_model_zero", 32'(model_cnt(AW'(20), AW'(30))), 32'd0);
        check("t2_model_640", 32'(model_cnt(AW'(21), AW'(31))), 32'd640);
        start_job(AW'(20), AW'(30), 13'd2);
        wait_done("t2_done", 200, k);

        // Address wrap on port A; a start pulse mid-job is ignored.
        mem_a[AW'(4094)] = rnd_row();
        mem_a[AW'(4095)] = rnd_row();
        mem_a[AW'(0)]    = rnd_row();
        mem_b[AW'(10)]   = rnd_row();
        mem_b[AW'(11)]   = rnd_row();
        mem_b[AW'(12)]   = rnd_row();
        start_job(AW'(4094), AW'(10), 13'd3);
        repeat (5) @(posedge clk_a);
        #1;
        start       = 1'b1;
        base_addr_a = AW'(100);
        n_rows      = 13'd5;
        @(posedge clk_a); #1;
        start = 1'b0;
        wait_done("t3_done", 300, k);

        // Back-pressure: outputs held while res_ready is low, no new issue.
        r = rnd_row();
        mem_a[AW'(50)] = r;
        r[99:0] = ~r[99:0];
        mem_b[AW'(60)] = r;
        hold_exp = model_cnt(AW'(50), AW'(60));
        check("t4_model_1180", 32'(hold_exp), 32'd1180);
        res_ready = 1'b0;
        start_job(AW'(50), AW'(60), 13'd1);
        k = 0;
        while (!res_valid && k < 60) begin
            @(negedge clk_a);
            k++;
        end
        check("t4_valid_seen", 32'(res_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_a);
            check("t4_hold_valid", 32'(res_valid), 32'd1);
            check("t4_hold_count", 32'(res_count), 32'(hold_exp));
            check("t4_hold_row", 32'(res_row), 32'd0);
            check("t4_hold_done", 32'(done), 32'd0);
        end
        @(posedge clk_a); #1;
        res_ready = 1'b1;
        wait_done("t4_done", 20, k);
        check("t4_done_after_hs", 32'(k), 32'd2);

        // Zero-row job: no reads, done two cycles after start.
        start_job(AW'(7), AW'(8), 13'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_a);
            check("t5_done", 32'(done), 32'(i == 2));
            check("t5_busy", 32'(busy), 32'(i <= 2));
        end

        // Reset in the middle of accumulation, then a clean job.
        mem_a[AW'(70)] = rnd_row();
        mem_a[AW'(71)] = rnd_row();
        mem_b[AW'(80)] = rnd_row();
        mem_b[AW'(81)] = rnd_row();
        start_job(AW'(70), AW'(80), 13'd2);
        repeat (10) @(negedge clk_a);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        addr_q.delete();
        exp_q.delete();
        @(posedge clk_a); #1;
        rst_n = 1'b1;
        start_job(AW'(70), AW'(80), 13'd2);
        wait_done("t6_done", 200, k);

        repeat (3) @(negedge clk_a);
        check("sb_results_drained", 32'(exp_q.size()), 32'd0);
        check("sb_addrs_drained", 32'(addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_xnor_popcnt.md
# bram_xnor_popcnt

Read-side consumer for the dual-port 1280-bit row BRAM. On `start` it reads `n_rows` row pairs, one row from port A and one from port B at independent base addresses. For each pair it computes the BNN binary dot product popcount(XNOR(row_a, row_b)) in 64-bit chunks and returns one count per row over a valid/ready handshake. It owns the BRAM read controls and sits between the BRAM and the neuron/threshold stage.

## Interface
Parameters:
- `DATA_W`, 1280: BRAM row width.
- `CHUNK_W`, 64: bits reduced per accumulate cycle. `DATA_W % CHUNK_W == 0` is required.
- `ADDR_W`, 12: BRAM address width.
- `RD_LAT`, 2: BRAM read latency in cycles, from `ena`/`addr` to `dout`. Must be ≥ 1.

Ports (derived widths: CNT_W = clog2(DATA_W+1) = 11):
- `clk_a` in 1: clock. Both BRAM ports are clocked by `clk_a`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `base_addr_a` in ADDR_W: first port-A row; latched on accepted start.
- `base_addr_b` in ADDR_W: first port-B row; latched on accepted start.
- `n_rows` in ADDR_W+1: row pairs to process; latched on accepted start.
- `busy` out 1: high from the cycle after accepted start until the done cycle.
- `done` out 1: one-cycle pulse at job end.
- `addr_a`, `addr_b` out ADDR_W: registered BRAM addresses.
- `ena_a`, `ena_b` out 1: registered BRAM enables. Ports are read-only; there is no write enable.
- `dout_a`, `dout_b` in DATA_W: BRAM read data.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts.
- `res_count` out CNT_W: popcount of XNOR for the current row pair.
- `res_row` out ADDR_W: row index within the job, 0-based.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPT, ACC, OUT, DONE.
- IDLE → ISSUE on `start`. If `n_rows` = 0, go IDLE → DONE instead; no reads are issued.
- ISSUE (1 cycle): `ena_a` = `ena_b` = 1, `addr_a` = base_a + row, `addr_b` = base_b + row, modulo 2^ADDR_W (wrap-around is silent).
- WAIT: lasts RD_LAT−1 cycles; enables low.
- CAPT: `dout_a` and `dout_b` are loaded into shift registers; accumulator is cleared.
- ACC: DATA_W/CHUNK_W cycles (20 at defaults). Each cycle, acc += popcount(~(sa ^ sb)) over the low CHUNK_W bits, then both shift registers shift right by CHUNK_W.
- OUT: `res_valid` = 1; `res_count` and `res_row` are held stable until `res_valid` && `res_ready`.
  - On the handshake: row++. If row == n_rows, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle): `done` = 1, then return to IDLE.
- `start` outside IDLE is ignored, with no side effects.
- Accumulator arithmetic is unsigned CNT_W bits. The maximum value 1280 fits, so it never overflows.
- Reset, including mid-job, forces the following and discards any in-flight job:
  - state = IDLE;
  - all outputs 0: `addr_*` = 0, `ena_*` = 0, `res_*` = 0, `busy` = 0, `done` = 0;
  - shift registers, accumulator and row counter = 0.

## Timing
- Row cycle, with ISSUE in cycle T:
  - BRAM data valid in cycle T+RD_LAT; captured at the end of that cycle.
  - ACC runs T+RD_LAT+1 … T+RD_LAT+20.
  - `res_valid` rises in cycle T+RD_LAT+21 (T+23 at defaults).
- Next ISSUE is the cycle after the handshake. The zero-stall period is RD_LAT+22 cycles per row; rows do not overlap.
- `done` asserts the cycle after the final handshake.
- For `n_rows` = 0, `done` asserts 2 cycles after the `start` cycle. `busy` is high in the cycle before `done` and in the `done` cycle.
- Each enable is high for exactly one cycle per row.

## Structure
- Shared package `bnn_pkg` holds:
  - `DATA_W`, `CHUNK_W`, `ADDR_W`, `CNT_W` constants;
  - the FSM state enum `xp_state_t`.
- One sub-module, `popcnt_chunk`: combinational popcount of CHUNK_W bits to clog2(CHUNK_W+1) bits, implemented as an adder tree. It is instantiated once.

## Test plan
- Identical rows, `n_rows` = 1, `res_ready` = 1 → `res_count` = 1280, `res_row` = 0. `res_valid` in cycle T+23; `done` one cycle after the handshake.
- Row A all ones, row B all zeros → `res_count` = 0. Row A = 0xAA… repeating, row B = 0 → `res_count` = 640.
- `base_addr_a` = 4094, `base_addr_b` = 10, `n_rows` = 3 → `addr_a` sequence 4094, 4095, 0 and `addr_b` sequence 10, 11, 12; three results with `res_row` = 0, 1, 2.
- `res_ready` held low for 7 cycles → `res_valid`, `res_count` and `res_row` are stable throughout; no new ISSUE occurs until the handshake.
- `start` pulsed while busy → ignored. `n_rows` = 0 → `ena_*` never asserts; `done` asserts 2 cycles after `start`.
- `rst_n` asserted mid-ACC → all outputs 0 immediately. A new job after release produces correct counts.
